swd_xfer_seq: RTL
=================

Name: swd_xfer_seq

Overview:
- Transfer sequencer directly upstream of the SWD pin-level engine.
- Accepts one DP/AP read or write command over a valid/ready handshake, holds the engine's command inputs stable, and pulses the engine's go/idle handshake.
- Automatically re-issues the transfer when the target answers WAIT, up to a configurable limit.
- Returns ack, read data, parity error and retry count over a valid/ready response channel.

Parameters:
RETRY_W, 16, width of retry limit input and retry counter.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command
cmd_apndp  in  1  AP(1)/DP(0)
cmd_rnw  in  1  read(1)/write(0)
cmd_addr32  in  2  address bits 3:2
cmd_wdata  in  32  write data
wait_retries  in  RETRY_W  maximum re-issues after WAIT (0 = no retry)
abort  in  1  suppress further retries of the current command
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_ack  out  3  final ack (001 OK, 010 WAIT, 100 FAULT, other = protocol error)
rsp_rdata  out  32  read data
rsp_perr  out  1  read parity error
rsp_retries  out  RETRY_W  number of WAIT re-issues performed
rsp_aborted  out  1  retries were cut short by abort
if_go  out  1  go to engine
if_idle  in  1  engine idle
if_apndp  out  1  to engine
if_rnw  out  1  to engine
if_addr32  out  2  to engine
if_dwrite  out  32  to engine
if_ack  in  3  engine ack
if_dread  in  32  engine read data
if_perr  in  1  engine parity error

Behaviour:
- Reset (async, active-high): state IDLE; cmd_ready=1; if_go=0; rsp_valid=0; rsp_ack=0; rsp_rdata=0; rsp_perr=0; rsp_retries=0; rsp_aborted=0; if_apndp/if_rnw/if_addr32/if_dwrite=0; retry counter=0; abort latch=0.
- Reset mid-transfer drops if_go immediately. The engine has its own reset and is not managed by this block.
- cmd_ready = (state==IDLE). Accept on cmd_valid&&cmd_ready.
- On accept, register all cmd_* fields onto the if_* outputs. These hold unchanged through every retry until the next accept.
- On accept, clear the retry counter and the abort latch.
- States:
  - IDLE: on accept -> LAUNCH.
  - LAUNCH: if_go=1. The engine samples go only on its internal strobe, so go is held until if_idle==0, then -> RUN with if_go=0 on the next cycle.
  - RUN: wait for if_idle==1 -> EVAL.
  - EVAL (one cycle): if if_ack==010, abort latch clear, and retry counter < wait_retries: increment the counter, -> LAUNCH. Otherwise capture the response fields below, -> RESP.
  - RESP: rsp_valid=1 held with stable data until rsp_ready, then -> IDLE (rsp_valid=0 next cycle). cmd_ready rises in the same cycle as that IDLE entry.
- Response capture in EVAL:
  - rsp_ack=if_ack; rsp_retries=counter.
  - rsp_rdata=if_dread only when rnw && if_ack==001, else 0.
  - rsp_perr=if_perr only when rnw && if_ack==001, else 0.
  - rsp_aborted = abort latch && if_ack==010.
- abort is sampled every cycle in LAUNCH, RUN and EVAL and sets the latch.
- An in-flight frame is never cut short; abort only prevents re-issue. abort in IDLE or RESP is ignored.
- Retry counter saturates at all-ones and never wraps. wait_retries is sampled live in EVAL.
- FAULT, protocol-error and OK acks are never retried.
- Minimum turnaround from accept to LAUNCH is 1 cycle. No command is accepted while a response is pending.

Test Plan:
1. DP read, addr32=00, engine returns ack 001, dread 0x2BA01477, perr 0 -> one go pulse; rsp_ack=001, rsp_rdata=0x2BA01477, rsp_retries=0.
2. AP write, addr32=11, wdata 0xDEADBEEF, wait_retries=3, engine gives WAIT,WAIT,OK -> exactly 3 go pulses; if_dwrite stays 0xDEADBEEF throughout; rsp_ack=001, rsp_retries=2, rsp_rdata=0.
3. wait_retries=2, engine always WAIT -> 3 go pulses; rsp_ack=010, rsp_retries=2, rsp_aborted=0.
4. wait_retries=100, always WAIT, abort pulsed during the 2nd frame -> 2nd frame completes, no 3rd go; rsp_ack=010, rsp_retries=1, rsp_aborted=1.
5. Read returning ack 001 with perr=1, then ack 100 -> rsp_perr=1 on the first; rsp_ack=100, rsp_rdata=0, no retry on the second.
6. Hold rsp_ready=0 for 10 cycles, then assert rst mid-LAUNCH on the next command -> the response stays stable while rsp_ready is low. On rst: if_go=0 and rsp_valid=0 asynchronously, cmd_ready=1 after reset release.

Source files
------------

// File: rtl/swd_xfer_seq.sv
// SWD transfer sequencer: holds one DP/AP command on the engine inputs, pulses go,
// re-issues on WAIT up to a live limit and returns the final response over valid/ready.
module swd_xfer_seq #(
    parameter int RETRY_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    // Handshakes: a transfer happens on the rising clk edge where valid && ready;
    // the source holds valid and its payload stable until that edge.
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_apndp,
    input  logic               cmd_rnw,
    input  logic [1:0]         cmd_addr32,
    input  logic [31:0]        cmd_wdata,
    input  logic [RETRY_W-1:0] wait_retries,
    input  logic               abort,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2:0]         rsp_ack,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_perr,
    output logic [RETRY_W-1:0] rsp_retries,
    output logic               rsp_aborted,
    output logic               if_go,
    input  logic               if_idle,
    output logic               if_apndp,
    output logic               if_rnw,
    output logic [1:0]         if_addr32,
    output logic [31:0]        if_dwrite,
    input  logic [2:0]         if_ack,
    input  logic [31:0]        if_dread,
    input  logic               if_perr,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_EVAL   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    localparam logic [2:0]         ACK_OK   = 3'b001;
    localparam logic [2:0]         ACK_WAIT = 3'b010;
    localparam logic [RETRY_W-1:0] CNT_ONE  = {{(RETRY_W-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [RETRY_W-1:0]   r_retry_cnt;
    logic                 r_abort;
    logic                 w_accept;
    logic                 w_retry;
    logic                 w_rd_ok;

    assign w_accept  = cmd_valid && (r_state == ST_IDLE);
    // The saturation guard is implied by the limit compare but kept explicit.
    assign w_retry   = (if_ack == ACK_WAIT) && !r_abort &&
                       (r_retry_cnt < wait_retries) && (r_retry_cnt != '1);
    assign w_rd_ok   = if_rnw && (if_ack == ACK_OK);
    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Strobes decode straight from the state register so reset clears them asynchronously.
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        if_go       = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if_go = 1'b1;
                if (!if_idle) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (if_idle) w_state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                w_state_nxt = w_retry ? ST_LAUNCH : ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_apndp    <= 1'b0;
            if_rnw      <= 1'b0;
            if_addr32   <= 2'b00;
            if_dwrite   <= 32'h0;
            r_retry_cnt <= '0;
            r_abort     <= 1'b0;
            rsp_ack     <= 3'b000;
            rsp_rdata   <= 32'h0;
            rsp_perr    <= 1'b0;
            rsp_retries <= '0;
            rsp_aborted <= 1'b0;
        end else begin
            if (w_accept) begin
                if_apndp    <= cmd_apndp;
                if_rnw      <= cmd_rnw;
                if_addr32   <= cmd_addr32;
                if_dwrite   <= cmd_wdata;
                r_retry_cnt <= '0;
                r_abort     <= 1'b0;
            end else if ((r_state == ST_LAUNCH || r_state == ST_RUN || r_state == ST_EVAL) && abort) begin
                r_abort <= 1'b1;
            end
            if (r_state == ST_EVAL) begin
                if (w_retry) begin
                    r_retry_cnt <= r_retry_cnt + CNT_ONE;
                end else begin
                    rsp_ack     <= if_ack;
                    rsp_retries <= r_retry_cnt;
                    rsp_rdata   <= w_rd_ok ? if_dread : 32'h0;
                    rsp_perr    <= w_rd_ok ? if_perr : 1'b0;
                    rsp_aborted <= r_abort && (if_ack == ACK_WAIT);
                end
            end
        end
    end

endmodule
